// File: rtl/fetch_prefetch_buffer.sv
// In-order instruction prefetcher feeding IF/ID through a DEPTH-entry, PC-tagged FIFO.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_prefetch_buffer #(
    parameter int            DW       = 32,
    parameter int            DEPTH    = 2,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] instr_o,
    output logic [DW-1:0] pc_o,
    output logic [DW-1:0] pc_plus_4_o
);

    localparam int            PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW  = PW + 1;
    localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);
    localparam logic [DW-1:0] PC_STEP = DW'(4);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] fetch_pc_reg, fetch_pc_next;
    logic [DW-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;

    logic [DW-1:0] fifo_instr_reg [DEPTH];
    logic [DW-1:0] fifo_pc_reg    [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic          rsp_valid;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          fifo_empty;
    logic          bypass;
    logic          pop;
    logic          pop_fifo;
    logic          push_fifo;
    logic          fire;
    logic [CW:0]   credit_used;
    logic [DW-1:0] redirect_pc_aligned;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_valid  = imem_rvalid_i & (outstanding_reg != '0);
    assign rsp_drop   = rsp_valid & (discard_reg != '0);
    assign rsp_keep   = rsp_valid & ~rsp_drop;
    assign fifo_empty = (count_reg == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty & rsp_keep & ~redirect_i;
`else
    assign bypass = 1'b0;
`endif

    assign valid_o   = ~fifo_empty | bypass;
    assign pop       = valid_o & ready_i;
    assign pop_fifo  = pop & ~fifo_empty;
    // A bypassed response that decode takes this cycle never occupies a slot.
    assign push_fifo = rsp_keep & ~(bypass & ready_i);

    // Buffered plus in-flight never exceeds DEPTH, so the FIFO cannot overflow.
    assign credit_used = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign imem_req_o  = (state_reg != S_BOOT) & ~redirect_i &
                         (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc_reg;
    assign fire        = imem_req_o & imem_gnt_i;

    assign redirect_pc_aligned = redirect_pc_i & ~DW'(3);

    always_comb begin
        instr_o = NOP;
        pc_o    = resp_pc_reg;
        if (!fifo_empty) begin
            instr_o = fifo_instr_reg[rd_ptr_reg];
            pc_o    = fifo_pc_reg[rd_ptr_reg];
        end else if (bypass) begin
            instr_o = imem_rdata_i;
        end
    end

    assign pc_plus_4_o = pc_o + PC_STEP;

    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        count_next       = count_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;

        if (redirect_i) begin
            // Everything still in flight after this edge belongs to the old stream.
            fetch_pc_next    = redirect_pc_aligned;
            resp_pc_next     = redirect_pc_aligned;
            count_next       = '0;
            rd_ptr_next      = '0;
            wr_ptr_next      = '0;
            outstanding_next = outstanding_reg - CW'(rsp_valid);
            discard_next     = outstanding_reg - CW'(rsp_valid);
            state_next       = (discard_next != '0) ? S_FLUSH : S_RUN;
        end else begin
            if (fire) begin
                fetch_pc_next = fetch_pc_reg + PC_STEP;
            end
            outstanding_next = outstanding_reg + CW'(fire) - CW'(rsp_valid);
            discard_next     = discard_reg - CW'(rsp_drop);
            if (rsp_keep) begin
                resp_pc_next = resp_pc_reg + PC_STEP;
            end
            if (push_fifo) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop_fifo) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            count_next = count_reg + CW'(push_fifo) - CW'(pop_fifo);

            case (state_reg)
                S_BOOT:  state_next = S_RUN;
                S_FLUSH: state_next = (discard_next == '0) ? S_RUN : S_FLUSH;
                S_RUN:   state_next = S_RUN;
                default: state_next = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg       <= S_BOOT;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_fifo & ~redirect_i & (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                fifo_instr_reg[i] <= imem_rdata_i;
                fifo_pc_reg[i]    <= resp_pc_reg;
            end
        end
    end

endmodule
